uart_rcv: RTL and testbench
===========================

# uart_rcv

Serial receiver paired with the 8N1 transmitter on the board's UART link. It samples the asynchronous `RX` line, reassembles one start bit, 8 data bits (LSB first) and one stop bit into a byte, and presents it to the command/packet layer with a ready flag. It also flags framing errors (bad stop bit) and overruns (unconsumed byte overwritten). It runs at the same bit period as the transmitter, so a TX-to-RX loopback is bit-exact.

## Interface
- `BAUD_CYCLES`, default 2604: clocks per bit. 50 MHz / 19200 baud.
- `HALF_CYCLES`, default `BAUD_CYCLES/2` (1302): clocks from start-edge detection to the start-bit sample point.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  serial line, asynchronous to `clk`, idle high.
- `clr_rdy`  in  1  consumer acknowledge: clears `rdy`, `frm_err` and `ovr_err`.
- `rx_data`  out  8  last good received byte.
- `rdy`  out  1  a new byte is valid in `rx_data`.
- `frm_err`  out  1  sticky: the last frame had a low stop bit.
- `ovr_err`  out  1  sticky: a byte completed while `rdy` was still set.

## Operation
- **Synchronizer.** `RX` passes through 2 flops, both reset to 1. All logic uses the second flop, `rx_s`. Pin-to-`rx_s` latency is 2 clocks.
- **Baud counter.** 12-bit down counter `cnt`. A sample strobe fires when `cnt == 0` and the state is not IDLE/WAIT_HIGH.
  - On each strobe `cnt` reloads with `BAUD_CYCLES-1`.
  - On entry to START, `cnt` loads `HALF_CYCLES-1`.
- **Bit counter.** 4 bits, cleared on entry to DATA, incremented on each DATA strobe.
- **Shift register.** 8 bits, shifts right with `rx_s` entering bit 7. After 8 shifts it holds the byte LSB-correct.
- **States.**
  - IDLE: if `rx_s == 0`, go to START.
  - START: on strobe, if `rx_s == 1` (glitch/false start) go to IDLE with no flags changed. Otherwise go to DATA.
  - DATA: on each strobe, shift. After the 8th strobe (bit counter 7 -> 8), go to STOP.
  - STOP, on strobe:
    - If `rx_s == 1`: load `rx_data` from the shift register and set `rdy`. If `rdy` was already 1 and `clr_rdy` is not asserted that cycle, also set `ovr_err`. Go to IDLE.
    - If `rx_s == 0`: set `frm_err`, leave `rx_data` and `rdy` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s == 1`, then go to IDLE. A held-low line or break never retriggers a frame.
- **Flag priority.** When a set and `clr_rdy` occur in the same cycle, the set wins for that flag. `clr_rdy` still clears the other flags.
- **Data retention.** `rx_data` changes only on a good stop bit. In an overrun it is overwritten with the newer byte.

## Timing
- **Reset values.** State IDLE; `rx_data = 8'h00`; `rdy = 0`; `frm_err = 0`; `ovr_err = 0`; `cnt = 0`; sync flops = 1.
- **Sample points.** Let T be the cycle IDLE first sees `rx_s == 0`.
  - Start sample at T+`HALF_CYCLES`.
  - Data bit k (k = 0..7) sampled at T+`HALF_CYCLES`+(k+1)·`BAUD_CYCLES`.
  - Stop sample at T+`HALF_CYCLES`+9·`BAUD_CYCLES` (T+24738 at defaults).
- **Outputs.** `rdy`, `rx_data` and the flags are registered and update at the stop-sample edge, so they are visible from the next cycle.
- **Re-arm.** After a good stop sample the block is back in IDLE on the next cycle. It can detect a new start bit within 1 clock, which allows back-to-back frames with zero extra idle.
- **Reset mid-frame.** Return to reset values immediately. The partial byte is discarded and no flag is set. A frame still in progress on the line is ignored until `rx_s` is seen high and then low again. A low `rx_s` at reset release starts a (likely false) frame, rejected by the START check if high by mid-bit.
- **Counter limit.** `BAUD_CYCLES` must be ≤ 4096 (12-bit counter).

## Test plan
- **Loopback.** Transmitter drives `RX` with byte 8'hA5 at `BAUD_CYCLES`=2604 -> `rdy` rises exactly once, T+24739 after start detection; `rx_data == 8'hA5`; `frm_err == 0`; `ovr_err == 0`.
- **Glitch rejection.** `RX` low for 500 clocks, then high -> state returns to IDLE after the start sample; `rdy`, `frm_err` and `rx_data` unchanged.
- **Framing error.** Frame 8'h3C with the stop bit driven low and `RX` held low 3 more bit times -> `frm_err = 1`, `rdy = 0`, `rx_data` keeps its old value, no new frame starts until `RX` goes high. The next good frame 8'h81 gives `rdy = 1` with `frm_err` still 1 until `clr_rdy`.
- **Overrun and clear priority.** Send 8'h11, then 8'h22 back-to-back without `clr_rdy` -> `rx_data = 8'h22`, `ovr_err = 1`. Repeat with `clr_rdy` pulsed in the exact stop-sample cycle of the second byte -> `rdy = 1`, `ovr_err = 0`.
- **Reset mid-frame.** Assert `rst_n` low during data bit 4 of 8'hF0 -> all outputs at reset values; the remainder of the frame produces no `rdy`; a following 8'h5A is received correctly.
- **Back-to-back extremes.** 8'h00 then 8'hFF with zero idle between frames -> two `rdy` pulses (acknowledged with `clr_rdy`), data 8'h00 then 8'hFF, no errors.

Source files
------------

// File: rtl/uart_rcv_if.sv
// Byte-level link between the UART receiver and the command/packet layer.
// The receiver uses the slave modport; the consumer uses the master modport.
interface uart_rcv_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  modport master (output RX, output clr_rdy,
                  input  rx_data, input rdy, input frm_err, input ovr_err);
  modport slave  (input  RX, input clr_rdy,
                  output rx_data, output rdy, output frm_err, output ovr_err);
endinterface

// File: rtl/uart_rcv.sv
// 8N1 serial receiver: synchronizes RX, samples mid-bit, and hands each byte to
// the consumer with a ready flag plus sticky framing/overrun flags.
module uart_rcv #(
  parameter int BAUD_CYCLES = 2604,
  parameter int HALF_CYCLES = BAUD_CYCLES / 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rcv_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_CYCLES - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(HALF_CYCLES - 1);

  logic       rx_meta_r;
  logic       rx_s;
  state_t     state_r;
  state_t     state_nxt;
  logic [11:0] cnt_r;
  logic [11:0] cnt_nxt;
  logic [3:0] bit_cnt_r;
  logic [3:0] bit_cnt_nxt;
  logic [7:0] shift_r;
  logic [7:0] shift_nxt;
  logic [7:0] rx_data_r;
  logic [7:0] rx_data_nxt;
  logic       rdy_r;
  logic       frm_err_r;
  logic       ovr_err_r;
  logic       rdy_nxt;
  logic       frm_err_nxt;
  logic       ovr_err_nxt;
  logic       strobe_s;
  logic       counting_s;
  logic       rdy_set_s;
  logic       frm_set_s;
  logic       ovr_set_s;

  // Two-flop synchronizer for the asynchronous RX pin; idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= bus.RX;
      rx_s      <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, baud/bit counters, shifter and flag set/clear decisions.
  always_comb begin
    counting_s  = (state_r != IDLE) && (state_r != WAIT_HIGH);
    strobe_s    = counting_s && (cnt_r == 12'd0);
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    rx_data_nxt = rx_data_r;
    rdy_set_s   = 1'b0;
    frm_set_s   = 1'b0;
    ovr_set_s   = 1'b0;

    if (strobe_s) begin
      cnt_nxt = BAUD_RELOAD;
    end else if (counting_s) begin
      cnt_nxt = cnt_r - 12'd1;
    end else begin
      cnt_nxt = cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = HALF_RELOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (strobe_s) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = 4'd0;
          end
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (strobe_s) begin
          shift_nxt   = {rx_s, shift_r[7:1]};
          bit_cnt_nxt = bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd7) begin
            state_nxt = STOP;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      STOP: begin
        if (strobe_s) begin
          if (rx_s) begin
            rx_data_nxt = shift_r;
            rdy_set_s   = 1'b1;
            ovr_set_s   = rdy_r && !bus.clr_rdy;
            state_nxt   = IDLE;
          end else begin
            frm_set_s = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          state_nxt = STOP;
        end
      end
      WAIT_HIGH: begin
        // A break or stuck-low line must not look like a fresh start bit.
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_HIGH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A set beats a simultaneous acknowledge for the same flag.
    rdy_nxt     = rdy_set_s ? 1'b1 : (bus.clr_rdy ? 1'b0 : rdy_r);
    frm_err_nxt = frm_set_s ? 1'b1 : (bus.clr_rdy ? 1'b0 : frm_err_r);
    ovr_err_nxt = ovr_set_s ? 1'b1 : (bus.clr_rdy ? 1'b0 : ovr_err_r);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 12'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      rx_data_r <= 8'h00;
      rdy_r     <= 1'b0;
      frm_err_r <= 1'b0;
      ovr_err_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      rx_data_r <= rx_data_nxt;
      rdy_r     <= rdy_nxt;
      frm_err_r <= frm_err_nxt;
      ovr_err_r <= ovr_err_nxt;
    end
  end

  assign bus.rx_data = rx_data_r;
  assign bus.rdy     = rdy_r;
  assign bus.frm_err = frm_err_r;
  assign bus.ovr_err = ovr_err_r;

endmodule

// File: tb/tb_uart_rcv.sv
// Bench for uart_rcv: one full-rate instance for exact loopback timing and one
// fast-baud instance driven from a frame table with a scoreboard of expected outputs.
module tb_uart_rcv;

  localparam int FAST_BAUD = 16;
  localparam int FAST_HALF = 8;
  // drive-to-visible-rdy: 2 sync flops + detect edge + half bit + 9 bits
  localparam int LOOP_LAT  = 3 + 1302 + 9 * 2604;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          hold_bits;
    int          idle;
    logic        ack;
    logic        clr_stop;
    logic        evt;
    logic [10:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   d_rises;
  int   d_rise_cyc;
  logic [10:0] sb_q[$];
  vec_t vecs[8];

  uart_rcv_if bus_d ();
  uart_rcv_if bus_s ();

  uart_rcv dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));
  uart_rcv #(.BAUD_CYCLES(FAST_BAUD), .HALF_CYCLES(FAST_HALF))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs_s();
    return {bus_s.rx_data, bus_s.rdy, bus_s.frm_err, bus_s.ovr_err};
  endfunction

  function automatic logic [10:0] outs_d();
    return {bus_d.rx_data, bus_d.rdy, bus_d.frm_err, bus_d.ovr_err};
  endfunction

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) bus_s.RX = v;
    else     bus_d.RX = v;
  endtask

  // start + 8 data (LSB first) + stop; optional acks during start bit or at the stop sample
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop,
                            input logic ack, input logic clr_stop,
                            input int baud, input int half);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive_rx(sel, bits[i]);
      if (i == 0 && ack) begin
        bus_s.clr_rdy = 1'b1;
        @(posedge clk); #1;
        bus_s.clr_rdy = 1'b0;
        repeat (baud - 1) @(posedge clk);
        #1;
      end else if (i == 9 && clr_stop) begin
        repeat (2 + half) @(posedge clk);
        #1;
        bus_s.clr_rdy = 1'b1;
        @(posedge clk); #1;
        bus_s.clr_rdy = 1'b0;
        repeat (baud - 3 - half) @(posedge clk);
        #1;
      end else begin
        repeat (baud) @(posedge clk);
        #1;
      end
    end
  endtask

  // Output-event monitor: scoreboard for the fast instance, rdy-rise log for the full-rate one.
  initial begin
    logic       p_rdy;
    logic       p_frm;
    logic       p_ovr;
    logic [7:0] p_data;
    logic       pd_rdy;
    p_rdy = 1'b0; p_frm = 1'b0; p_ovr = 1'b0; p_data = 8'h00; pd_rdy = 1'b0;
    d_rises = 0;
    d_rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((bus_s.rdy && !p_rdy) || (bus_s.rx_data != p_data) ||
            (bus_s.frm_err && !p_frm) || (bus_s.ovr_err && !p_ovr)) begin
          if (sb_q.size() == 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL unexpected_output: got 0x%0h, want no output event", outs_s());
          end else begin
            check("rx_event", 32'(outs_s()), 32'(sb_q.pop_front()));
          end
        end
        if (bus_d.rdy && !pd_rdy) begin
          d_rises = d_rises + 1;
          d_rise_cyc = cyc;
        end
      end
      p_rdy  = bus_s.rdy;
      p_frm  = bus_s.frm_err;
      p_ovr  = bus_s.ovr_err;
      p_data = bus_s.rx_data;
      pd_rdy = bus_d.rdy;
    end
  end

  initial begin
    int c0;
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{8'h3C, 1'b0, 3, 4, 1'b0, 1'b0, 1'b1, {8'h00, 1'b0, 1'b1, 1'b0}};
    vecs[1] = '{8'h81, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, {8'h81, 1'b1, 1'b1, 1'b0}};
    vecs[2] = '{8'h11, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, {8'h11, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{8'h22, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, {8'h22, 1'b1, 1'b0, 1'b1}};
    vecs[4] = '{8'h11, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, {8'h11, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{8'h22, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, {8'h22, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{8'h00, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{8'hFF, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, {8'hFF, 1'b1, 1'b0, 1'b0}};

    bus_d.RX = 1'b1; bus_d.clr_rdy = 1'b0;
    bus_s.RX = 1'b1; bus_s.clr_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s", 32'(outs_s()), 32'h0);
    check("reset_d", 32'(outs_d()), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_s", 32'(outs_s()), 32'h0);

    // Glitch shorter than half a bit on the full-rate instance.
    bus_d.RX = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    bus_d.RX = 1'b1;
    repeat (2000) @(posedge clk);
    #1;
    check("glitch_d", 32'(outs_d()), 32'h0);

    // Full-rate loopback with exact rdy timing.
    c0 = cyc;
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 2604, 1302);
    repeat (200) @(posedge clk);
    #1;
    check("loop_rises", 32'(d_rises), 32'd1);
    check("loop_latency", 32'(d_rise_cyc - c0), 32'(LOOP_LAT));
    check("loop_outputs", 32'(outs_d()), 32'({8'hA5, 1'b1, 1'b0, 1'b0}));

    // Frame table on the fast instance, back-to-back unless idle is requested.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].evt) sb_q.push_back(vecs[i].exp);
      send_frame(1'b1, vecs[i].data, vecs[i].stop, vecs[i].ack, vecs[i].clr_stop,
                 FAST_BAUD, FAST_HALF);
      if (vecs[i].hold_bits > 0) begin
        repeat (vecs[i].hold_bits * FAST_BAUD) @(posedge clk);
        #1;
      end
      if (vecs[i].idle > 0) begin
        bus_s.RX = 1'b1;
        repeat (vecs[i].idle) @(posedge clk);
        #1;
      end
    end
    repeat (20) @(posedge clk);
    #1;
    check("table_drained", 32'(sb_q.size()), 32'd0);

    // Acknowledge, then a 4-cycle glitch on the fast instance.
    bus_s.clr_rdy = 1'b1;
    @(posedge clk); #1;
    bus_s.clr_rdy = 1'b0;
    bus_s.RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus_s.RX = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_s", 32'(outs_s()), 32'({8'hFF, 1'b0, 1'b0, 1'b0}));

    // Reset during data bit 4 of 8'hF0.
    bus_s.RX = 1'b0;
    repeat (FAST_BAUD) @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      bus_s.RX = 1'b0;
      repeat (FAST_BAUD) @(posedge clk);
      #1;
    end
    bus_s.RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mid_frame", 32'(outs_s()), 32'h0);
    rst_n = 1'b1;
    repeat (4 * FAST_BAUD + 10) @(posedge clk);
    #1;
    check("after_reset_no_rdy", 32'(outs_s()), 32'h0);
    sb_q.push_back({8'h5A, 1'b1, 1'b0, 1'b0});
    send_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, FAST_BAUD, FAST_HALF);
    repeat (20) @(posedge clk);
    #1;
    check("final_drained", 32'(sb_q.size()), 32'd0);
    check("final_outputs", 32'(outs_s()), 32'({8'h5A, 1'b1, 1'b0, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
